sample_scheduler: RTL and testbench
===================================

SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter K, default 24, sample width in bits.
REQ-002 Parameter DIV, default 5000, sample-tick divider terminal count; tick period is DIV+1 clk cycles.
REQ-003 Parameter TMO, default 4096, filter-wait timeout in clk cycles; used only with the timeout feature.
REQ-004 clk  in  1  single system clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 bypass  in  1  1 = skip filter and send the raw sample to the codec; sampled only at tick.
REQ-007 audio_in  in  K  raw sample from the source, signed.
REQ-008 filt_out  in  K  filter result, signed.
REQ-009 filt_done  in  1  one-cycle pulse; filt_out valid in the same cycle.
REQ-010 codec_ready  in  1  codec accepts new L/R words while high.
REQ-011 sample  out  1  one-cycle start pulse to the filter.
REQ-012 l_bus, r_bus  out  K  words to the codec; both always carry identical values.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 overrun  out  1  sticky; set when a tick arrives outside IDLE.
REQ-015 timeout  out  1  sticky; set on filter-wait expiry.

Function
REQ-016 Divider counts 0..DIV and wraps to 0; tick is asserted in the cycle the count equals DIV.
REQ-017 FSM states: IDLE, WAIT_DONE, HOLD.
REQ-018 IDLE with tick and bypass=0: capture audio_in into in_reg, pulse sample in the next cycle, go to WAIT_DONE.
REQ-019 IDLE with tick and bypass=1: capture audio_in into in_reg and result, no sample pulse, go to HOLD.
REQ-020 WAIT_DONE with filt_done: capture filt_out into result, go to HOLD; filt_done in any other state is ignored.
REQ-021 HOLD with codec_ready: l_bus and r_bus take result at the next edge, go to IDLE; without codec_ready, stay in HOLD.
REQ-022 l_bus and r_bus change only on a HOLD-to-IDLE transition and otherwise hold their value.
REQ-023 A tick outside IDLE is dropped, sets overrun, and does not change state or in_reg.
REQ-024 A tick coinciding with filt_done in WAIT_DONE: filt_done is processed and overrun is set.
REQ-025 Latency in bypass mode is 1 cycle from tick to HOLD; bus update occurs at the first codec_ready cycle in HOLD.
REQ-026 No arithmetic is performed on samples; widths pass through unchanged at K bits.

Reset
REQ-027 Reset clears the divider to 0 and sets the state to IDLE.
REQ-028 Reset drives sample, busy, overrun and timeout to 0, and drives l_bus, r_bus, in_reg and result to 0.
REQ-029 Reset mid-operation, in any state, takes effect at the next edge and abandons the current sample with no bus update.

Configuration
REQ-030 Macro SAMPLE_SCHED_TIMEOUT_EN compiles in the filter-wait watchdog.
REQ-031 With SAMPLE_SCHED_TIMEOUT_EN defined: a counter clears on WAIT_DONE entry and increments each WAIT_DONE cycle. On reaching TMO without filt_done: result takes in_reg, timeout is set, and the FSM goes to HOLD. If filt_done arrives in the same cycle as expiry, filt_done wins and timeout stays 0.
REQ-032 With SAMPLE_SCHED_TIMEOUT_EN undefined: WAIT_DONE waits indefinitely, and timeout is tied to 0.

Verification
REQ-033 DIV=9, bypass=1, audio_in=24'h123456, codec_ready=1: l_bus=r_bus=24'h123456 within 3 cycles of the tick; sample is never asserted.
REQ-034 DIV=9, bypass=0, filt_done 4 cycles after sample with filt_out=24'hFFF000: exactly one sample pulse per tick, and l_bus=24'hFFF000.
REQ-035 codec_ready held low for 15 cycles in HOLD with DIV=9: the next tick sets overrun, and the bus updates when codec_ready rises.
REQ-036 SAMPLE_SCHED_TIMEOUT_EN, TMO=8, no filt_done: after 8 WAIT_DONE cycles timeout=1 and l_bus equals the captured audio_in.
REQ-037 Reset asserted in WAIT_DONE, with filt_done arriving 1 cycle later: state is IDLE, l_bus=0, all flags 0, and filt_done is ignored.

Source files
------------

// File: rtl/sample_scheduler_if.sv
// Handshake bundle between the sample scheduler, its audio source, the filter
// and the codec. The scheduler takes the slave view; a driver or bench takes the master view.
interface sample_sched_if #(
  parameter int K = 24
) ();
  logic         bypass;
  logic [K-1:0] audio_in;
  logic [K-1:0] filt_out;
  logic         filt_done;
  logic         codec_ready;
  logic         sample;
  logic [K-1:0] l_bus;
  logic [K-1:0] r_bus;
  logic         busy;
  logic         overrun;
  logic         timeout;

  modport slave (
    input  bypass, audio_in, filt_out, filt_done, codec_ready,
    output sample, l_bus, r_bus, busy, overrun, timeout
  );

  modport master (
    output bypass, audio_in, filt_out, filt_done, codec_ready,
    input  sample, l_bus, r_bus, busy, overrun, timeout
  );
endinterface

// File: rtl/sample_scheduler.sv
// Periodic sample scheduler: divider tick -> (optional filter pass) -> codec L/R words.
// Optional filter-wait watchdog compiled in with SAMPLE_SCHED_TIMEOUT_EN.
module sample_scheduler #(
  parameter int K   = 24,
  parameter int DIV = 5000,
  parameter int TMO = 4096
) (
  input  logic          clk,
  input  logic          reset,
  sample_sched_if.slave io
);

  localparam int            CW     = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [CW-1:0] DIV_TC = CW'(DIV);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [K-1:0]  in_reg;
  logic [K-1:0]  result;
  logic [K-1:0]  bus_q;
  logic          sample_q;
  logic          overrun_q;
  logic          tmo_hit;
  logic          busy_c;

  // ---------------------------------------------------------------------------
  // Sample-rate divider: period DIV+1, tick on the terminal count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)               div_cnt <= '0;
    else if (div_cnt == DIV_TC) div_cnt <= '0;
    else                     div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_TC);

  // ---------------------------------------------------------------------------
  // Filter-wait watchdog
  // ---------------------------------------------------------------------------
`ifdef SAMPLE_SCHED_TIMEOUT_EN
  localparam int            TW     = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [TW-1:0] TMO_TC = TW'(TMO - 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_q;

  // Held at zero outside WAIT_DONE so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset)                   wait_cnt <= '0;
    else if (state != WAIT_DONE) wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + 1'b1;
  end

  // A filter result landing on the expiry cycle takes priority over the watchdog.
  assign tmo_hit = (state == WAIT_DONE) && (wait_cnt == TMO_TC) && !io.filt_done;

  always_ff @(posedge clk) begin
    if (reset)        timeout_q <= 1'b0;
    else if (tmo_hit) timeout_q <= 1'b1;
  end

  assign io.timeout = timeout_q;
`else
  localparam int tmo_unused = TMO;
  logic in_reg_unused;

  // Without the watchdog the captured raw sample is never read back.
  assign in_reg_unused = ^in_reg;
  assign tmo_hit       = 1'b0;
  assign io.timeout    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (tick) state_nxt = io.bypass ? HOLD : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (io.filt_done || tmo_hit) state_nxt = HOLD;
      end
      HOLD: begin
        if (io.codec_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_c = 1'b1;
    if (state == IDLE) busy_c = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      in_reg    <= '0;
      result    <= '0;
      bus_q     <= '0;
      sample_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sample_q <= (state == IDLE) && tick && !io.bypass;

      if ((state == IDLE) && tick) begin
        in_reg <= io.audio_in;
        if (io.bypass) result <= io.audio_in;
      end

      if (state == WAIT_DONE) begin
        if (io.filt_done)  result <= io.filt_out;
        else if (tmo_hit)  result <= in_reg;
      end

      if ((state == HOLD) && io.codec_ready) bus_q <= result;

      // Ticks outside IDLE are dropped; only the sticky flag records them.
      if (tick && (state != IDLE)) overrun_q <= 1'b1;
    end
  end

  assign io.sample  = sample_q;
  assign io.l_bus   = bus_q;
  assign io.r_bus   = bus_q;
  assign io.busy    = busy_c;
  assign io.overrun = overrun_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler: a cycle-level behavioural model compared every
// cycle, plus literal expectations for the key scenarios (timeout ones follow the macro).
`timescale 1ns/1ps
module tb_sample_scheduler;
  localparam int K   = 24;
  localparam int DIV = 9;
  localparam int TMO = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sample_sched_if #(.K(K)) sif ();

  sample_scheduler #(.K(K), .DIV(DIV), .TMO(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (sif)
  );

  int vectors = 0;
  int errs    = 0;
  int t       = 0;
  int spulses = 0;

  // filter responder: answers a sample pulse filt_delay cycles later (<=0 = silent)
  logic resp_done  = 1'b0;
  logic filt_force = 1'b0;
  int   filt_delay = -1;
  int   cd         = 0;
  assign sif.filt_done = resp_done | filt_force;

  always @(negedge clk) begin
    if (reset) begin
      cd        = 0;
      resp_done = 1'b0;
    end else begin
      resp_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) resp_done = 1'b1;
      end
      if (sif.sample === 1'b1 && filt_delay > 0) cd = filt_delay;
    end
  end

  always @(negedge clk) if (sif.sample === 1'b1) spulses++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at t=%0d: got %h expected %h", nm, t, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: cycles since reset give the tick; two flags give the phase
  // ---------------------------------------------------------------------------
  bit           m_ok = 0;
  int           mc, m_wc;
  bit           m_wait, m_hold, m_sample, m_ovr, m_tmo;
  logic [K-1:0] m_in, m_res, m_bus;

  always @(posedge clk) begin
    bit tk, idle;
    if (reset) begin
      m_ok = 1; mc = 0; m_wc = 0;
      m_wait = 0; m_hold = 0; m_sample = 0; m_ovr = 0; m_tmo = 0;
      m_in = '0; m_res = '0; m_bus = '0;
    end else begin
      tk   = ((mc % (DIV + 1)) == DIV);
      mc++;
      idle = !m_wait && !m_hold;
      m_sample = 0;
      if (tk && !idle) m_ovr = 1;
      if (idle) begin
        if (tk) begin
          m_in = sif.audio_in;
          if (sif.bypass) begin m_res = sif.audio_in; m_hold = 1; end
          else begin m_wait = 1; m_sample = 1; m_wc = 0; end
        end
      end else if (m_wait) begin
        m_wc++;
        if (sif.filt_done) begin
          m_res = sif.filt_out; m_wait = 0; m_hold = 1;
        end
`ifdef SAMPLE_SCHED_TIMEOUT_EN
        else if (m_wc >= TMO) begin
          m_res = m_in; m_tmo = 1; m_wait = 0; m_hold = 1;
        end
`endif
      end else if (sif.codec_ready) begin
        m_bus = m_res; m_hold = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("sample",  32'(sif.sample),  32'(m_sample));
      chk("l_bus",   32'(sif.l_bus),   32'(m_bus));
      chk("r_bus",   32'(sif.r_bus),   32'(m_bus));
      chk("busy",    32'(sif.busy),    32'(m_wait | m_hold));
      chk("overrun", 32'(sif.overrun), 32'(m_ovr));
      chk("timeout", 32'(sif.timeout), 32'(m_tmo));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    t       = 0;
    spulses = 0;
  endtask

  task automatic go(input int n);
    while (t < n) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    int n;
    sif.bypass = 1'b0; sif.audio_in = '0; sif.filt_out = '0; sif.codec_ready = 1'b0;

    // reset state
    do_reset();
    chk("rst_l_bus",   32'(sif.l_bus),   32'h0);
    chk("rst_busy",    32'(sif.busy),    32'h0);
    chk("rst_overrun", 32'(sif.overrun), 32'h0);
    chk("rst_sample",  32'(sif.sample),  32'h0);

    // bypass: tick in cycle 9, HOLD in 10, bus visible in 11; never a sample pulse
    sif.bypass = 1'b1; sif.audio_in = 24'h123456; sif.codec_ready = 1'b1;
    do_reset();
    n = 0;
    while (sif.l_bus !== 24'h123456 && n < 20) begin
      @(negedge clk);
      n++;
    end
    t = n;
    chk("byp_latency", 32'(n), 32'd11);
    go(25);
    chk("byp_pulses", 32'(spulses), 32'd0);
    chk("byp_r_bus",  32'(sif.r_bus), 32'h123456);

    // filtered path: filter answers 4 cycles after sample; four ticks by cycle 39
    sif.bypass = 1'b0; sif.audio_in = 24'h0A0B0C; sif.filt_out = 24'hFFF000;
    filt_delay = 4;
    do_reset();
    go(45);
    chk("flt_pulses",  32'(spulses),     32'd4);
    chk("flt_l_bus",   32'(sif.l_bus),   32'hFFF000);
    chk("flt_overrun", 32'(sif.overrun), 32'h0);

    // filt_done coinciding with the next tick: processed, overrun set
    sif.filt_out = 24'h00F00D;
    filt_delay = 9;
    do_reset();
    go(22);
`ifndef SAMPLE_SCHED_TIMEOUT_EN
    chk("coin_overrun", 32'(sif.overrun), 32'h1);
    chk("coin_l_bus",   32'(sif.l_bus),   32'h00F00D);
`endif

    // codec stalls for 15 HOLD cycles; tick at 19 is dropped without touching in_reg
    sif.bypass = 1'b1; sif.codec_ready = 1'b0; sif.audio_in = 24'h0ABCDE;
    filt_delay = -1;
    do_reset();
    go(15);
    sif.audio_in = 24'h111111;
    go(25);
    chk("stall_l_bus",   32'(sif.l_bus),   32'h0);
    chk("stall_busy",    32'(sif.busy),    32'h1);
    chk("stall_overrun", 32'(sif.overrun), 32'h1);
    sif.codec_ready = 1'b1;
    go(26);
    chk("stall_release", 32'(sif.l_bus), 32'h0ABCDE);

    // silent filter: watchdog expiry after 8 WAIT_DONE cycles (10..17)
    sif.bypass = 1'b0; sif.audio_in = 24'h5A5A5A;
    do_reset();
    go(19);
`ifdef SAMPLE_SCHED_TIMEOUT_EN
    chk("tmo_flag",  32'(sif.timeout), 32'h1);
    chk("tmo_l_bus", 32'(sif.l_bus),   32'h5A5A5A);
`else
    chk("tmo_flag",  32'(sif.timeout), 32'h0);
    chk("tmo_busy",  32'(sif.busy),    32'h1);
    chk("tmo_l_bus", 32'(sif.l_bus),   32'h0);
`endif

    // filt_done on the expiry cycle wins over the watchdog
    do_reset();
    go(17);
    sif.filt_out = 24'h00BEEF; filt_force = 1'b1;
    go(18);
    filt_force = 1'b0;
    go(20);
    chk("race_timeout", 32'(sif.timeout), 32'h0);
    chk("race_l_bus",   32'(sif.l_bus),   32'h00BEEF);

    // reset in WAIT_DONE, filt_done one cycle later must be ignored
    sif.audio_in = 24'h777777; sif.filt_out = 24'h333333;
    do_reset();
    go(12);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; filt_force = 1'b1; t = 0;
    go(1);
    filt_force = 1'b0;
    go(2);
    chk("mid_busy",    32'(sif.busy),    32'h0);
    chk("mid_l_bus",   32'(sif.l_bus),   32'h0);
    chk("mid_overrun", 32'(sif.overrun), 32'h0);
    chk("mid_timeout", 32'(sif.timeout), 32'h0);
    chk("mid_sample",  32'(sif.sample),  32'h0);
    go(6);
    chk("mid_r_bus",   32'(sif.r_bus),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
